weight_rom_sequencer: RTL and testbench

- Sequences burst reads from the local weight ROM and streams the words to the accelerator datapath over a valid/ready interface.
- The ROM is a synchronous read memory: an address sampled at one edge gives data on the next cycle. It has no enable and no flow control.
- This block hides the 1-cycle read latency behind a 2-entry skid FIFO. It sustains 1 word/cycle and tolerates arbitrary backpressure.
- Instantiated next to the ROM inside the acc subsystem. start/base/len come from the host-side control registers.

---
 rtl/weight_rom_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_weight_rom_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_rom_sequencer.sv
// weight_rom_sequencer: reads bursts from a synchronous weight ROM and streams
// the words to the accelerator datapath. The ROM's 1-cycle read latency is
// absorbed by a 2-entry skid FIFO, so the block sustains 1 word/cycle and
// tolerates arbitrary backpressure.
// Optional feature macro: WEIGHT_ROM_SEQUENCER_CHECKSUM_EN adds an XOR
// checksum output over every word delivered in the current burst.
//
// Handshake: a word transfers at a rising edge where out_valid & out_ready are
// both high. Once out_valid rises it stays high, with out_data and out_last
// held stable, until that transfer happens. out_ready never reaches rom_addr
// combinationally; it only steers counter and pointer updates.
module weight_rom_sequencer #(
    parameter int ByteWidth = 12,
    parameter int AddrWidth = 6,
    localparam int DW = ByteWidth * 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] base_addr,
    input  logic [AddrWidth:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic [AddrWidth-1:0] rom_addr,
    input  logic [DW-1:0]        rom_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_last
`ifdef WEIGHT_ROM_SEQUENCER_CHECKSUM_EN
    ,
    output logic [DW-1:0]        checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AddrWidth:0]   CntOne  = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] AddrOne = {{(AddrWidth-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic                 done_d;
    logic                 done_q;
    logic [AddrWidth-1:0] rom_addr_q;
    logic [AddrWidth:0]   issue_cnt_q;
    logic [AddrWidth:0]   deliver_cnt_q;
    logic                 rd_vld_q;
    logic [1:0]           count_q;
    logic [DW-1:0]        head_q;
    logic [DW-1:0]        tail_q;

    logic                 pop;
    logic                 push;
    logic                 accept;
    logic                 issue;
    logic                 last_pop;
    logic [2:0]           occupancy;

    // Handshake decode and the issue rule: a read is only launched when the
    // word it returns is guaranteed a free FIFO slot on the following edge.
    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        push      = rd_vld_q;
        accept    = (state_q == IDLE) && start;
        occupancy = {1'b0, count_q} + {2'b00, rd_vld_q} - {2'b00, pop};
        issue     = (state_q == RUN) && (issue_cnt_q != '0) && (occupancy <= 3'd1);
        last_pop  = pop && (deliver_cnt_q == CntOne);
    end

    // Next-state and done-pulse decode for the burst controller.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue && (issue_cnt_q == CntOne)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Address generator plus issue/deliver counters; start while busy never
    // reaches here because accept is qualified with IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q    <= '0;
            issue_cnt_q   <= '0;
            deliver_cnt_q <= '0;
            rd_vld_q      <= 1'b0;
        end else begin
            rd_vld_q <= issue;
            if (accept && (len != '0)) begin
                rom_addr_q    <= base_addr;
                issue_cnt_q   <= len;
                deliver_cnt_q <= len;
            end else begin
                if (issue) begin
                    rom_addr_q  <= rom_addr_q + AddrOne;
                    issue_cnt_q <= issue_cnt_q - CntOne;
                end
                if (pop) begin
                    deliver_cnt_q <= deliver_cnt_q - CntOne;
                end
            end
        end
    end

    // Two-entry skid FIFO: head_q feeds the output directly, tail_q holds the
    // second word when the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= rom_dout;
                    end else begin
                        tail_q <= rom_dout;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= rom_dout;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= rom_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The issue rule keeps at most one word in flight beyond the FIFO contents.
    assert property (@(posedge clk) disable iff (rst) !(push && (count_q == 2'd2)));

`ifdef WEIGHT_ROM_SEQUENCER_CHECKSUM_EN
    logic [DW-1:0] checksum_q;

    // Running XOR of delivered words; cleared when a new burst is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q ^ head_q;
        end
    end

    assign checksum = checksum_q;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign out_last  = out_valid && (deliver_cnt_q == CntOne);

endmodule

// File: tb/tb_weight_rom_sequencer.sv
// Bench for weight_rom_sequencer: a burst-level reference model (queue of the
// words each accepted burst must deliver) checked from a negedge monitor,
// plus directed latency, wrap, len==0 and reset scenarios and randomized
// bursts with random backpressure and ignored start pulses.
module tb_weight_rom_sequencer;
  localparam int ByteWidth = 12;
  localparam int AddrWidth = 6;
  localparam int DW = ByteWidth * 8;
  localparam int Depth = 1 << AddrWidth;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic [AddrWidth-1:0] base_addr = '0;
  logic [AddrWidth:0]   len = '0;
  logic                 busy;
  logic                 done;
  logic [AddrWidth-1:0] rom_addr;
  logic [DW-1:0]        rom_dout = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DW-1:0]        out_data;
  logic                 out_last;
`ifdef WEIGHT_ROM_SEQUENCER_CHECKSUM_EN
  logic [DW-1:0]        checksum;
`endif

  weight_rom_sequencer #(.ByteWidth(ByteWidth), .AddrWidth(AddrWidth)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef WEIGHT_ROM_SEQUENCER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Synchronous ROM: mem[i] = i replicated in every byte.
  logic [DW-1:0] mem [Depth];
  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = {ByteWidth{8'(i)}};
  end
  always @(posedge clk) rom_dout <= mem[rom_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]        exp_q[$];
  logic                 model_busy = 1'b0;
  logic                 done_exp = 1'b0;
  logic [DW-1:0]        model_cks = '0;
  logic [AddrWidth-1:0] model_end_addr = '0;
  logic                 prev_stall = 1'b0;
  logic [DW-1:0]        prev_data = '0;
  int                   total_pops = 0;
  logic                 ready_mode = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  // Outputs are compared against the model state first, then the model is
  // advanced for the transfers that will happen at the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_busy = 1'b0;
      done_exp   = 1'b0;
      model_cks  = '0;
      prev_stall = 1'b0;
    end else begin
      check("busy", busy, model_busy);
      check("done", done, done_exp);
`ifdef WEIGHT_ROM_SEQUENCER_CHECKSUM_EN
      check("checksum", checksum, model_cks);
`endif
      check("out_last", out_last, out_valid && (exp_q.size() == 1));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid) check("valid_has_word", exp_q.size() != 0, 1'b1);
      done_exp = 1'b0;
      if (start && !model_busy) begin
        model_cks = '0;
        if (len == '0) begin
          done_exp = 1'b1;
        end else begin
          for (int i = 0; i < int'(len); i++) begin
            logic [AddrWidth-1:0] a;
            a = base_addr + AddrWidth'(i);
            exp_q.push_back(mem[a]);
          end
          model_busy     = 1'b1;
          model_end_addr = base_addr + len[AddrWidth-1:0];
        end
      end
      if (out_valid && out_ready && (exp_q.size() != 0)) begin
        check("out_data", out_data, exp_q.pop_front());
        model_cks = model_cks ^ out_data;
        total_pops++;
        if (exp_q.size() == 0) begin
          model_busy = 1'b0;
          done_exp   = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_burst(input logic [AddrWidth-1:0] b, input logic [AddrWidth:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    len = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Random start pulses while a burst is running; the DUT must ignore them.
  task automatic junk_starts();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (!model_busy) break;
      start = ($urandom_range(0, 3) == 0);
      base_addr = AddrWidth'($urandom);
      len = (AddrWidth+1)'($urandom_range(0, Depth));
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(input logic chk_addr);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (!model_busy && !done_exp) begin
        idle = 1'b1;
        break;
      end
    end
    check("idle_reached", idle, 1'b1);
    if (chk_addr) check("end_rom_addr", rom_addr, model_end_addr);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [AddrWidth-1:0] b;
    logic [AddrWidth:0]   l;
    int p0;
    int r;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_rom_addr", rom_addr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Latency and full-rate streaming with out_ready held high.
    ready_mode = 1'b0;
    start_burst(0, 4);
    @(negedge clk); check("lat_e0", out_valid, 1'b0);
    @(negedge clk); check("lat_e1", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("stream_valid", out_valid, 1'b1);
    end
    @(negedge clk); check("stream_end", out_valid, 1'b0);
    wait_idle(1'b1);
    @(negedge clk); check("busy_after", busy, 1'b0);

    // Address wrap through 0.
    start_burst(62, 4);
    wait_idle(1'b1);

    // len == 0: done one cycle after start, never busy.
    start_burst(5, 0);
    @(negedge clk);
    check("len0_done", done, 1'b1);
    check("len0_busy", busy, 1'b0);
    check("len0_valid", out_valid, 1'b0);
    @(negedge clk);
    check("len0_done_clr", done, 1'b0);

    // Backpressured burst of 8.
    ready_mode = 1'b1;
    start_burst(10, 8);
    wait_idle(1'b1);

    // Reset mid-burst after 5 pops, then a clean short burst.
    ready_mode = 1'b0;
    start_burst(0, 16);
    p0 = total_pops;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (total_pops - p0 >= 5) break;
    end
    check("pops_before_rst", total_pops - p0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rom_addr", rom_addr, '0);
    start_burst(0, 2);
    wait_idle(1'b1);

    // Full-ROM burst from a random base.
    ready_mode = 1'b1;
    start_burst(AddrWidth'($urandom), (AddrWidth+1)'(Depth));
    junk_starts();
    wait_idle(1'b1);

    // Randomized bursts with random backpressure and ignored starts.
    for (int n = 0; n < 25; n++) begin
      b = AddrWidth'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) l = '0;
      else if (r == 1) l = (AddrWidth+1)'(Depth);
      else l = (AddrWidth+1)'($urandom_range(1, 20));
      start_burst(b, l);
      if (l != '0) junk_starts();
      wait_idle(l != '0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
